// File: rtl/vector_multiply_pipe_if.sv
// Stream interface for vector_multiply_pipe: operand beats in, result beats out.
// Latency: none; this is a bundle of wires with valid/ready on each direction.
// Backpressure: datain_ready and dout_ready carry stall information; see modports.
//
// Ports (slave = the multiplier's view, master = the producer/consumer view):
//   datain[2*W*N]   {operand1 vector, operand0 vector}, lane i at [i*W +: W] per half
//   datain_mode     0 = element-wise, 1 = dot product, travels with the beat
//   datain_valid / datain_ready   input handshake
//   dout[W*N]       result vector, same lane packing
//   dout_valid / dout_ready       output handshake
//   dout_sat        only with VECTOR_MULTIPLY_PIPE_SAT_EN: a lane saturated in this beat
// Parameters must match the ones given to vector_multiply_pipe.
interface vector_multiply_pipe_if #(
   parameter int C_OP_WIDTH  = 16,
   parameter int C_NUM_LANES = 4
);
   logic [2*C_OP_WIDTH*C_NUM_LANES-1:0] datain;
   logic                                datain_mode;
   logic                                datain_valid;
   logic                                datain_ready;
   logic [C_OP_WIDTH*C_NUM_LANES-1:0]   dout;
   logic                                dout_valid;
   logic                                dout_ready;
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
   logic                                dout_sat;

   modport slave (
      input  datain, datain_mode, datain_valid, dout_ready,
      output datain_ready, dout, dout_valid, dout_sat
   );
   modport master (
      output datain, datain_mode, datain_valid, dout_ready,
      input  datain_ready, dout, dout_valid, dout_sat
   );
`else
   modport slave (
      input  datain, datain_mode, datain_valid, dout_ready,
      output datain_ready, dout, dout_valid
   );
   modport master (
      output datain, datain_mode, datain_valid, dout_ready,
      input  datain_ready, dout, dout_valid
   );
`endif
endinterface

// File: rtl/vector_multiply_pipe.sv
// Lane-wise vector multiplier (element-wise or dot product), round-shifted and narrowed.
// Latency: C_LATENCY cycles from accepted beat to dout_valid when not stalled.
// Backpressure: per-stage valid/ready with bubble collapse; holds up to C_LATENCY beats.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (clears valid bits, dout, dout_sat)
//   bus   vector_multiply_pipe_if.slave carrying datain/dout streams
// Optional feature: define VECTOR_MULTIPLY_PIPE_SAT_EN to saturate instead of wrap
// when narrowing, which also enables bus.dout_sat.
module vector_multiply_pipe #(
   parameter int C_OP_WIDTH  = 16,
   parameter int C_NUM_LANES = 4,
   parameter int C_LATENCY   = 2,
   parameter int C_OUT_SHIFT = 0,
   parameter int C_SIGNED    = 1
) (
   input logic                  clk,
   input logic                  rst,
   vector_multiply_pipe_if.slave bus
);

   localparam int W  = C_OP_WIDTH;
   localparam int N  = C_NUM_LANES;
   localparam int L  = C_LATENCY;
   localparam int PW = 2 * W;
   // One bit beyond the full dot-sum width so the rounding add cannot overflow.
   localparam int EW = 2 * W + $clog2(C_NUM_LANES) + 1;
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
   localparam int RW = W + 1;   // narrowed value plus saturation flag in the MSB
`else
   localparam int RW = W;
`endif

   // Half-LSB of the shifted result; zero when no shift is applied.
   localparam logic [EW-1:0] RND = ({{(EW-1){1'b0}}, 1'b1} << C_OUT_SHIFT) >> 1;

   // ------------------------------------------------------------------
   // Stage storage: stages 1..L-1 carry full products, stage L is dout.
   // ------------------------------------------------------------------
   logic          s_vld  [1:L-1];
   logic          s_mode [1:L-1];
   logic [PW-1:0] s_prod [1:L-1][N];

   logic [W*N-1:0] dout_q;
   logic           dout_valid_q;
   logic [L:1]     ld;          // stage k loads from stage k-1 this cycle

   logic [W-1:0]   op0 [N];
   logic [W-1:0]   op1 [N];
   logic [PW-1:0]  mul [N];

   logic [RW-1:0]  lane_res [N];
   logic [RW-1:0]  dot_res;
   logic [EW-1:0]  dot_sum;
   logic [W*N-1:0] dout_next;
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
   logic           sat_next;
   logic           dout_sat_q;
`endif

   // Sign- or zero-extend a full product to the rounding width.
   function automatic logic [EW-1:0] extend(input logic [PW-1:0] p);
      logic s;
      s = (C_SIGNED != 0) ? p[PW-1] : 1'b0;
      return {{(EW-PW){s}}, p};
   endfunction

   // Round half up, then shift right (arithmetic when signed).
   function automatic logic [EW-1:0] shr(input logic [EW-1:0] x);
      logic [EW-1:0] r;
      r = x + RND;
      if (C_SIGNED != 0)
         return EW'($signed(r) >>> C_OUT_SHIFT);
      else
         return r >> C_OUT_SHIFT;
   endfunction

`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
   // Clamp to the output range; MSB of the return value flags a clamp.
   function automatic logic [RW-1:0] narrow(input logic [EW-1:0] x);
      logic [EW-1:0] r;
      r = shr(x);
      if (C_SIGNED != 0) begin
         // In range when every bit from W-1 upward equals the sign bit.
         if ((&r[EW-1:W-1]) || !(|r[EW-1:W-1]))
            return {1'b0, r[W-1:0]};
         else if (r[EW-1])
            return {1'b1, 1'b1, {(W-1){1'b0}}};
         else
            return {1'b1, 1'b0, {(W-1){1'b1}}};
      end else begin
         if (|r[EW-1:W])
            return {1'b1, {W{1'b1}}};
         else
            return {1'b0, r[W-1:0]};
      end
   endfunction
`else
   // Wrap: keep the low W bits.
   function automatic logic [RW-1:0] narrow(input logic [EW-1:0] x);
      return W'(shr(x));
   endfunction
`endif

   // ------------------------------------------------------------------
   // Input unpack and lane multipliers (operands extended to 2W so the
   // PW-wide product is exact in both signed and unsigned modes).
   // ------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < N; i++) begin
         op0[i] = bus.datain[i*W +: W];
         op1[i] = bus.datain[N*W + i*W +: W];
         mul[i] = {{W{(C_SIGNED != 0) ? op0[i][W-1] : 1'b0}}, op0[i]} *
                  {{W{(C_SIGNED != 0) ? op1[i][W-1] : 1'b0}}, op1[i]};
      end
   end

   // ------------------------------------------------------------------
   // Load enables. A stage loads when empty or when its successor loads,
   // so ld[k] is true if any stage from k to the output can take a beat.
   // No term depends on datain_valid.
   // ------------------------------------------------------------------
   always_comb begin
      logic acc;
      acc   = !dout_valid_q || bus.dout_ready;
      ld    = '0;
      ld[L] = acc;
      for (int k = L - 1; k >= 1; k--) begin
         acc   = acc || !s_vld[k];
         ld[k] = acc;
      end
   end

   assign bus.datain_ready = ld[1];

   // ------------------------------------------------------------------
   // Output stage arithmetic: dot sum, rounding, shift, narrowing.
   // ------------------------------------------------------------------
   always_comb begin
      dot_sum   = '0;
      dout_next = '0;
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
      sat_next  = 1'b0;
`endif
      for (int i = 0; i < N; i++) begin
         lane_res[i] = narrow(extend(s_prod[L-1][i]));
         dot_sum     = dot_sum + extend(s_prod[L-1][i]);
      end
      dot_res = narrow(dot_sum);

      if (s_mode[L-1]) begin
         // Dot result in lane 0, remaining lanes stay zero.
         dout_next[W-1:0] = dot_res[W-1:0];
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
         sat_next = dot_res[W];
`endif
      end else begin
         for (int i = 0; i < N; i++) begin
            dout_next[i*W +: W] = lane_res[i][W-1:0];
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
            sat_next = sat_next | lane_res[i][W];
`endif
         end
      end
   end

   // ------------------------------------------------------------------
   // Valid chain and output register (reset).
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k < L; k++)
            s_vld[k] <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
         dout_sat_q   <= 1'b0;
`endif
      end else begin
         if (ld[1])
            s_vld[1] <= bus.datain_valid;
         for (int k = 2; k < L; k++)
            if (ld[k])
               s_vld[k] <= s_vld[k-1];
         if (ld[L]) begin
            dout_valid_q <= s_vld[L-1];
            // dout only changes on a real beat, so it holds 0 after reset.
            if (s_vld[L-1]) begin
               dout_q <= dout_next;
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
               dout_sat_q <= sat_next;
`endif
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Intermediate payload (no reset; qualified by the valid chain).
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (ld[1] && bus.datain_valid) begin
         s_mode[1] <= bus.datain_mode;
         for (int i = 0; i < N; i++)
            s_prod[1][i] <= mul[i];
      end
      for (int k = 2; k < L; k++) begin
         if (ld[k] && s_vld[k-1]) begin
            s_mode[k] <= s_mode[k-1];
            for (int i = 0; i < N; i++)
               s_prod[k][i] <= s_prod[k-1][i];
         end
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
   assign bus.dout_sat   = dout_sat_q;
`endif

endmodule

// File: tb/tb_vector_multiply_pipe.sv
// Directed bench for vector_multiply_pipe: reset, element-wise, dot, rounding,
// saturation/wrap, backpressure, full throughput and reset during a stall.
// A second instance with C_OUT_SHIFT=4 covers the rounding path.
module tb_vector_multiply_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vector_multiply_pipe_if #(.C_OP_WIDTH(16), .C_NUM_LANES(4)) bus ();
   vector_multiply_pipe_if #(.C_OP_WIDTH(16), .C_NUM_LANES(4)) bus_s ();

   vector_multiply_pipe dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   vector_multiply_pipe #(.C_OUT_SHIFT(4)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pack four lane values (lane 0 first) into a 64-bit vector.
   function automatic logic [63:0] v4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic drive(input logic v, input logic m, input logic [63:0] o0, input logic [63:0] o1);
      bus.datain_valid = v;
      bus.datain_mode  = m;
      bus.datain       = {o1, o0};
   endtask

   task automatic drive_s(input logic v, input logic m, input logic [63:0] o0, input logic [63:0] o1);
      bus_s.datain_valid = v;
      bus_s.datain_mode  = m;
      bus_s.datain       = {o1, o0};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int k_in, n_out, held, cyc, j_in, first, last, stalls;
      logic acc_in, acc_out, stalled, md;
      logic [63:0] prev, e0, e1, ex;
      logic [63:0] expq[$];

      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0);
      drive_s(1'b0, 1'b0, '0, '0);
      bus.dout_ready   = 1'b1;
      bus_s.dout_ready = 1'b1;

      // ---------------- reset and basic element-wise beat ----------------
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_dout_valid", bus.dout_valid, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_ready", bus.datain_ready, 1);
      drive(1'b1, 1'b0, v4(4, -3, 100, 0), v4(5, 7, -2, 9));
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0);
      chk("t1_not_yet", bus.dout_valid, 0);
      @(negedge clk);
      chk("t1_valid", bus.dout_valid, 1);
      chk("t1_dout", bus.dout, v4(20, -21, -200, 0));
      @(negedge clk);
      chk("t1_drained", bus.dout_valid, 0);

      // ---------------- dot with shift 4, rounding on element-wise ----------------
      drive_s(1'b1, 1'b1, v4(16, 16, 16, 16), v4(1, 2, 3, 4));
      @(negedge clk);
      drive_s(1'b1, 1'b0, v4(7, -9, 8, -8), v4(1, 1, 1, 1));
      @(negedge clk);
      drive_s(1'b0, 1'b0, '0, '0);
      chk("dot_sh4_valid", bus_s.dout_valid, 1);
      chk("dot_sh4", bus_s.dout, v4(10, 0, 0, 0));
      @(negedge clk);
      chk("round_sh4", bus_s.dout, v4(0, -1, 1, 0));

      // ---------------- dot (shift 0) then saturation/wrap ----------------
      drive(1'b1, 1'b1, v4(1, 2, 3, 4), v4(-1, 5, 6, -7));
      @(negedge clk);
      drive(1'b1, 1'b0, v4(-32768, -32768, 0, 0), v4(-32768, 32767, 0, 0));
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0);
      chk("dot_neg", bus.dout, v4(-1, 0, 0, 0));
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
      chk("dot_nosat", bus.dout_sat, 0);
`endif
      @(negedge clk);
`ifdef VECTOR_MULTIPLY_PIPE_SAT_EN
      chk("sat_lanes", bus.dout, v4(32767, -32768, 0, 0));
      chk("sat_flag", bus.dout_sat, 1);
`else
      chk("wrap_lanes", bus.dout, v4(0, -32768, 0, 0));
`endif

      // ---------------- backpressure: ready 1,0,0,1 ----------------
      k_in = 1; n_out = 0; held = 0; cyc = 0; stalled = 1'b0; prev = '0;
      while (n_out < 10 && cyc < 200) begin
         @(negedge clk);
         if (stalled) begin
            chk("bp_hold_valid", bus.dout_valid, 1);
            chk("bp_hold_dout", bus.dout, prev);
         end
         bus.dout_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         if (k_in <= 10) drive(1'b1, 1'b0, v4(k_in, k_in, k_in, k_in), v4(1, 1, 1, 1));
         else            drive(1'b0, 1'b0, '0, '0);
         #1;
         chk("bp_ready", bus.datain_ready, !(held == 2 && !bus.dout_ready));
         acc_in  = bus.datain_valid && bus.datain_ready;
         acc_out = bus.dout_valid && bus.dout_ready;
         if (acc_out) begin
            n_out++;
            chk("bp_order", bus.dout, v4(n_out, n_out, n_out, n_out));
         end
         stalled = bus.dout_valid && !bus.dout_ready;
         prev    = bus.dout;
         if (acc_in) k_in++;
         held = held + int'(acc_in) - int'(acc_out);
         cyc++;
      end
      chk("bp_count", n_out, 10);
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0);
      bus.dout_ready = 1'b1;
      chk("bp_no_dup", bus.dout_valid, 0);

      // ---------------- full throughput, mixed modes ----------------
      j_in = 0; n_out = 0; cyc = 0; first = -1; last = -1; stalls = 0;
      while (n_out < 64 && cyc < 300) begin
         @(negedge clk);
         if (j_in < 64) begin
            md = (j_in % 3 == 0);
            e0 = v4(j_in, j_in + 1, j_in + 2, j_in + 3);
            e1 = v4(-2, -1, 0, 1);
            drive(1'b1, md, e0, e1);
         end else begin
            md = 1'b0;
            drive(1'b0, 1'b0, '0, '0);
         end
         #1;
         if (bus.datain_valid && !bus.datain_ready) stalls++;
         acc_in  = bus.datain_valid && bus.datain_ready;
         acc_out = bus.dout_valid && bus.dout_ready;
         if (acc_in) begin
            if (first < 0) first = cyc;
            // products: -2j, -(j+1), 0, j+3; dot sum 2-2j
            ex = md ? v4(2 - 2 * j_in, 0, 0, 0) : v4(-2 * j_in, -(j_in + 1), 0, j_in + 3);
            expq.push_back(ex);
            j_in++;
         end
         if (acc_out) begin
            last = cyc;
            n_out++;
            if (expq.size() > 0) chk("tp_data", bus.dout, expq.pop_front());
            else                 chk("tp_extra", bus.dout_valid, 0);
         end
         cyc++;
      end
      chk("tp_count", n_out, 64);
      chk("tp_cycles", last - first, 65);
      chk("tp_stalls", stalls, 0);

      // ---------------- reset while full and stalled ----------------
      @(negedge clk);
      bus.dout_ready = 1'b0;
      drive(1'b1, 1'b0, v4(50, 50, 50, 50), v4(1, 1, 1, 1));
      @(negedge clk);
      drive(1'b1, 1'b0, v4(51, 51, 51, 51), v4(1, 1, 1, 1));
      @(negedge clk);
      drive(1'b1, 1'b0, v4(52, 52, 52, 52), v4(1, 1, 1, 1));
      @(negedge clk);
      #1;
      chk("rm_full_ready", bus.datain_ready, 0);
      chk("rm_full_dout", bus.dout, v4(50, 50, 50, 50));
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b0;
      bus.dout_ready = 1'b1;
      #1;
      chk("rm_valid", bus.dout_valid, 0);
      chk("rm_dout", bus.dout, 0);
      chk("rm_ready", bus.datain_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rm_no_stale", bus.dout_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
